// File: rtl/mvm_uart_pkg.sv
// Shared widths and state encodings for the UART-attached matrix-vector multiplier.
// Widths are functions so every module derives them from its own parameters.
package mvm_uart_pkg;

  function automatic int calc_w_y(int w_x, int w_k, int c);
    return w_x + w_k + $clog2(c);
  endfunction

  function automatic int calc_w_bus_kx(int r, int c, int w_k, int w_x);
    return r * c * w_k + c * w_x;
  endfunction

  function automatic int calc_w_bus_y(int r, int w_y);
    return r * w_y;
  endfunction

  function automatic int calc_n_words(int w_bus, int bits_per_word);
    return w_bus / bits_per_word;
  endfunction

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

endpackage

// File: rtl/mvm_uart_sys_rx.sv
// 8N1-style byte receiver: mid-bit sampling, stop bit not checked, 1-cycle m_valid.
module uart_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     m_valid,
  output logic [BITS_PER_WORD-1:0] m_data
);
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam logic [CW-1:0] LAST      = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);

  rx_state_t state, state_n;
  logic rx_s1, rx_s2, rx_q;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [BITS_PER_WORD-1:0] shreg;

  // Two-flop synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) state <= RX_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:  if (rx_q && !rx_s2) state_n = RX_START;
      RX_START: if (cnt == HALF_LAST) state_n = RX_DATA;
      RX_DATA:  if (cnt == LAST && bit_idx == BIT_LAST) state_n = RX_STOP;
      RX_STOP:  if (cnt == LAST) state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state == RX_STOP) && (cnt == LAST);
    m_data  = shreg;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == RX_IDLE || state_n != state || cnt == LAST) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_IDLE) bit_idx <= '0;
      if (state == RX_DATA && cnt == LAST) begin
        shreg   <= {rx_s2, shreg[BITS_PER_WORD-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mvm_uart_sys.sv
// Top: assembles K/x from UART bytes, computes y = K*x (signed), streams y back over UART.
// y_reg doubles as the one-deep result buffer; TX copies it into its shifter on LOAD.
module mvm_uart_sys
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 5,
  parameter int R                = 8,
  parameter int C                = 8,
  parameter int W_X              = 8,
  parameter int W_K              = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);
  localparam int W_Y        = calc_w_y(W_X, W_K, C);
  localparam int W_BUS_KX   = calc_w_bus_kx(R, C, W_K, W_X);
  localparam int W_BUS_Y    = calc_w_bus_y(R, W_Y);
  localparam int N_WORDS_KX = calc_n_words(W_BUS_KX, BITS_PER_WORD);
  localparam int N_WORDS_Y  = calc_n_words(W_BUS_Y, BITS_PER_WORD);
  localparam int W_P        = W_X + W_K;
  localparam int KW = $clog2(N_WORDS_KX);
  localparam int YW = $clog2(N_WORDS_Y);
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(PACKET_SIZE_TX);

  logic                     rx_valid;
  logic [BITS_PER_WORD-1:0] rx_data;

  uart_rx #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_rx (
    .clk    (clk),
    .rstn   (rstn),
    .rx     (rx),
    .m_valid(rx_valid),
    .m_data (rx_data)
  );

  logic [W_BUS_KX-1:0] kx_bus;
  logic [KW-1:0]       byte_cnt;
  logic                kx_valid;

  always_ff @(posedge clk) begin
    if (rstn) begin
      kx_bus   <= '0;
      byte_cnt <= '0;
      kx_valid <= 1'b0;
    end else begin
      kx_valid <= 1'b0;
      if (rx_valid) begin
        kx_bus[int'(byte_cnt)*BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
        if (byte_cnt == KW'(N_WORDS_KX - 1)) begin
          byte_cnt <= '0;
          kx_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  logic [W_BUS_Y-1:0]     y_comb;
  logic signed [W_Y-1:0]  acc;
  logic signed [W_P-1:0]  prod;
  logic signed [W_K-1:0]  kv;
  logic signed [W_X-1:0]  xv;

  always_comb begin
    y_comb = '0;
    acc    = '0;
    prod   = '0;
    kv     = '0;
    xv     = '0;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        kv   = kx_bus[C*W_X + (r*C + c)*W_K +: W_K];
        xv   = kx_bus[c*W_X +: W_X];
        prod = W_P'(kv) * W_P'(xv);
        acc  = acc + W_Y'(prod);
      end
      y_comb[r*W_Y +: W_Y] = acc;
    end
  end

  tx_state_t           state, state_n;
  logic [W_BUS_Y-1:0]  y_reg, shifter;
  logic                y_pend;
  logic [CW-1:0]       clk_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [YW-1:0]       word_cnt;
  logic                bit_end, frame_end, last_word, tx_d;

  assign bit_end   = (clk_cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign frame_end = bit_end && (bit_cnt == BW'(PACKET_SIZE_TX - 1));
  assign last_word = (word_cnt == YW'(N_WORDS_Y - 1));

  always_ff @(posedge clk) begin
    if (rstn) begin
      y_reg  <= '0;
      y_pend <= 1'b0;
    end else if (kx_valid) begin
      y_reg  <= y_comb;
      y_pend <= 1'b1;
    end else if (state == TX_LOAD) begin
      y_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) state <= TX_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE: if (y_pend) state_n = TX_LOAD;
      TX_LOAD: state_n = TX_SEND;
      TX_SEND: if (frame_end && last_word) state_n = TX_IDLE;
      default: state_n = TX_IDLE;
    endcase
  end

  // Next line level: start bit, data LSB first, then ones up to the frame length
  always_comb begin
    tx_d = 1'b1;
    case (state)
      TX_LOAD: tx_d = 1'b0;
      TX_SEND: begin
        if (!bit_end) tx_d = tx;
        else if (bit_cnt != BW'(PACKET_SIZE_TX - 1)) begin
          if (int'(bit_cnt) + 1 <= BITS_PER_WORD) tx_d = shifter[int'(bit_cnt)];
          else tx_d = 1'b1;
        end else if (!last_word) tx_d = 1'b0;
        else tx_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      tx       <= 1'b1;
      shifter  <= '0;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      tx <= tx_d;
      if (state == TX_LOAD) begin
        shifter  <= y_reg;
        clk_cnt  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (state == TX_SEND) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        if (bit_end) bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
        if (frame_end) begin
          word_cnt <= word_cnt + 1'b1;
          shifter  <= shifter >> BITS_PER_WORD;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_uart_sys.sv
// Bench for mvm_uart_sys: drives UART bytes, decodes TX frames and scores results against a queue.
module tb_mvm_uart_sys;
  localparam int CPP = 4;
  localparam int NKX = 72;
  localparam int NY  = 19;
  localparam int WY  = 19;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rx = 1'b1;
  logic tx;

  int n_checks = 0;
  int n_pass   = 0;
  int frames_seen = 0;
  logic mon_busy = 1'b0;
  logic [151:0] exp_q[$];

  always #5 clk = ~clk;

  mvm_uart_sys dut (
    .clk (clk),
    .rstn(rstn),
    .rx  (rx),
    .tx  (tx)
  );

  initial begin
    #1200000;
    $display("FAIL watchdog: run did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // TX decoder: samples each bit at its middle, collects NY bytes per result
  initial begin : monitor
    logic [151:0] ybus;
    logic [151:0] e;
    logic [7:0]   b;
    logic         ok;
    int           nbyte;
    nbyte = 0;
    ybus  = '0;
    forever begin
      @(negedge clk);
      if (rstn == 1'b0 && tx === 1'b0) begin
        mon_busy = 1'b1;
        repeat (CPP/2) @(negedge clk);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPP) @(negedge clk);
          b[i] = tx;
        end
        for (int i = 0; i < 4; i++) begin
          repeat (CPP) @(negedge clk);
          if (tx !== 1'b1) ok = 1'b0;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL framing frame %0d: start/stop bits wrong, need start 0 and four 1s", frames_seen);
        ybus[nbyte*8 +: 8] = b;
        nbyte++;
        frames_seen++;
        if (nbyte == NY) begin
          nbyte = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL result: unexpected y %h, need no result", ybus);
          end else begin
            e = exp_q.pop_front();
            if (ybus !== e) $display("FAIL result: got y %h, need %h", ybus, e);
            else n_pass++;
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  function automatic logic [151:0] model_y(input logic [575:0] kx);
    logic [151:0] y;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < 8; c++)
        acc += int'($signed(kx[64 + (r*8 + c)*8 +: 8])) * int'($signed(kx[c*8 +: 8]));
      y[r*WY +: WY] = acc[18:0];
    end
    return y;
  endfunction

  function automatic logic [151:0] splat_y(input logic [18:0] v);
    logic [151:0] y;
    for (int r = 0; r < 8; r++) y[r*WY +: WY] = v;
    return y;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPP) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic send_exp(input logic [575:0] kx, input logic [151:0] y_exp, input int gmax);
    exp_q.push_back(y_exp);
    for (int n = 0; n < NKX; n++) begin
      send_byte(kx[n*8 +: 8]);
      repeat ((gmax <= 1) ? 1 : $urandom_range(1, gmax)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() == 0 && !mon_busy) n_pass++;
    else $display("FAIL %s drain: %0d results pending, need 0", name, exp_q.size());
  endtask

  task automatic test_reset();
    logic bad;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset tx: got %b, need 1", tx);
    else n_pass++;
    rstn = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL idle tx: got activity, need constant 1");
    else n_pass++;
  endtask

  task automatic test_zero();
    send_exp('0, '0, 1);
    wait_drain("zero");
  endtask

  task automatic test_identity();
    logic [575:0] kx;
    kx = '0;
    for (int c = 0; c < 8; c++) kx[c*8 +: 8] = 8'h01;
    for (int r = 0; r < 8; r++) kx[64 + (r*8 + r)*8 +: 8] = 8'h01;
    send_exp(kx, splat_y(19'd1), 1);
    wait_drain("identity");
  endtask

  task automatic test_min_min();
    logic [575:0] kx;
    for (int n = 0; n < NKX; n++) kx[n*8 +: 8] = 8'h80;
    send_exp(kx, splat_y(19'h20000), 1);
    wait_drain("min_min");
  endtask

  task automatic test_max_min();
    logic [575:0] kx;
    for (int n = 0; n < 8; n++) kx[n*8 +: 8] = 8'h80;
    for (int n = 8; n < NKX; n++) kx[n*8 +: 8] = 8'h7F;
    send_exp(kx, splat_y(19'h60400), 1);
    wait_drain("max_min");
  endtask

  task automatic test_random();
    logic [575:0] kx;
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < 18; i++) kx[i*32 +: 32] = $urandom();
      send_exp(kx, model_y(kx), 20);
      repeat ($urandom_range(1, 100)) @(negedge clk);
    end
    wait_drain("random");
  endtask

  task automatic test_reset_mid();
    logic [575:0] kx;
    logic bad;
    int f0;
    for (int i = 0; i < 18; i++) kx[i*32 +: 32] = $urandom();
    for (int n = 0; n < 30; n++) begin
      send_byte(kx[n*8 +: 8]);
      @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ~kx[30*8 + i];
      repeat (CPP) @(negedge clk);
    end
    rstn = 1'b1;
    rx   = 1'b1;
    bad  = 1'b0;
    @(negedge clk);
    repeat (6) begin
      if (tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) $display("FAIL reset_mid tx: got 0 during reset, need 1");
    else n_pass++;
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    f0 = frames_seen;
    for (int i = 0; i < 18; i++) kx[i*32 +: 32] = $urandom();
    send_exp(kx, model_y(kx), 3);
    wait_drain("reset_mid");
    repeat (1500) @(negedge clk);
    n_checks++;
    if (frames_seen - f0 != NY) $display("FAIL reset_mid frames: got %0d, need %0d", frames_seen - f0, NY);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero();
    test_identity();
    test_min_min();
    test_max_min();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
